// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK     = 8'hFF;
    localparam int unsigned BLINK_HALF_MS = 250;

    // Active-low segment patterns, entry n is hex digit n (bit 7 = dp off)
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] an_mask(input int unsigned idx,
                                           input int unsigned ndig,
                                           input bit          active_low);
        logic [7:0] m;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < ndig && i == idx) m[i] = 1'b1;
        end
        return active_low ? ~m : m;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low g..a segment decode.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nib][6:0];
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed NDIG-digit 7-segment driver with frame latch, leading-zero blanking and PWM.
// Optional blinking per digit is enabled by defining SEG7_BLINK_EN.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NDIG          = 4,
    parameter int unsigned PWM_BITS      = 3,
    parameter bit          AN_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  R,
    input  logic                  ce1ms,
    input  logic [4*NDIG-1:0]     dat,
    input  logic [NDIG-1:0]       dp,
    input  logic                  blank_lz,
    input  logic [PWM_BITS-1:0]   bright,
`ifdef SEG7_BLINK_EN
    input  logic [NDIG-1:0]       blink,
`endif
    output logic [NDIG-1:0]       AN,
    output logic [7:0]            SEG
);

    localparam int unsigned    IW     = $clog2(NDIG);
    localparam logic [NDIG-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;

    logic [IW-1:0]       idx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [4*NDIG-1:0]   dat_l;
    logic [NDIG-1:0]     dp_l;
    logic                wrap;

    assign wrap = ce1ms && (idx == IW'(NDIG - 1));

    // The whole frame is latched only as the scan wraps, so one scan never mixes two frames
    always_ff @(posedge clk) begin
        if (R) begin
            idx     <= '0;
            pwm_cnt <= '0;
            dat_l   <= '0;
            dp_l    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (wrap) begin
                idx   <= '0;
                dat_l <= dat;
                dp_l  <= dp;
            end else if (ce1ms) begin
                idx <= idx + 1'b1;
            end
        end
    end

    logic [NDIG-1:0] blink_mask;

`ifdef SEG7_BLINK_EN
    logic [7:0] blink_cnt;
    logic       blink_phase;

    always_ff @(posedge clk) begin
        if (R) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (ce1ms) begin
            if (blink_cnt == 8'(BLINK_HALF_MS - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        blink_mask = blink_phase ? blink : '0;
    end
`else
    always_comb begin
        blink_mask = '0;
    end
`endif

    logic [NDIG-1:0] lz_blank;
    logic            zero_above;
    logic [3:0]      nib;
    logic            dp_cur;
    logic            blanked;
    logic            lit;
    logic [6:0]      seg_g2a;

    // Digit k is a leading zero when it and every digit above it are zero; digit 0 never blanks
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int unsigned k = NDIG - 1; k >= 1; k--) begin
            zero_above  = zero_above & (dat_l[4*k +: 4] == 4'h0);
            lz_blank[k] = blank_lz & zero_above;
        end
    end

    always_comb begin
        nib     = '0;
        dp_cur  = 1'b0;
        blanked = 1'b0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (idx == IW'(k)) begin
                nib     = dat_l[4*k +: 4];
                dp_cur  = dp_l[k];
                blanked = lz_blank[k] | blink_mask[k];
            end
        end
        lit = (bright == '1) || (pwm_cnt < bright);
    end

    seg7_hex_decode u_hex (
        .nib (nib),
        .seg (seg_g2a)
    );

    always_ff @(posedge clk) begin
        if (R) begin
            AN  <= AN_OFF;
            SEG <= SEG_BLANK;
        end else if (lit && !blanked) begin
            AN  <= NDIG'(an_mask(32'(idx), NDIG, AN_ACTIVE_LOW));
            SEG <= {~dp_cur, seg_g2a};
        end else begin
            AN  <= AN_OFF;
            SEG <= SEG_BLANK;
        end
    end

endmodule
